// File: rtl/cpu_axi_master_if.sv
// AXI4 single-beat channel bundle between cpu_axi_master and its slave.
interface cpu_axi_master_if #(
    parameter int ID_BITS = 4
);
    logic [ID_BITS-1:0] AWID;
    logic [31:0]        AWADDR;
    logic [3:0]         AWLEN;
    logic [2:0]         AWSIZE;
    logic [1:0]         AWBURST;
    logic               AWVALID;
    logic               AWREADY;

    logic [31:0]        WDATA;
    logic [3:0]         WSTRB;
    logic               WLAST;
    logic               WVALID;
    logic               WREADY;

    logic [ID_BITS-1:0] BID;
    logic [1:0]         BRESP;
    logic               BVALID;
    logic               BREADY;

    logic [ID_BITS-1:0] ARID;
    logic [31:0]        ARADDR;
    logic [3:0]         ARLEN;
    logic [2:0]         ARSIZE;
    logic [1:0]         ARBURST;
    logic               ARVALID;
    logic               ARREADY;

    logic [ID_BITS-1:0] RID;
    logic [31:0]        RDATA;
    logic [1:0]         RRESP;
    logic               RLAST;
    logic               RVALID;
    logic               RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/cpu_axi_master.sv
// Single-outstanding AXI4 master: turns the core's held request/stall port
// into one single-beat read (AR/R) or write (AW/W/B) transaction at a time.
module cpu_axi_master #(
    parameter int ID_BITS   = 4,
    parameter int MASTER_ID = 0
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        core_req,
    input  logic [31:0] core_addr,
    input  logic [3:0]  core_web,
    input  logic [31:0] core_wdata,
    output logic        core_stall,
    output logic [31:0] core_rdata,
    output logic        core_err,
    cpu_axi_master_if.master axi
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE
    } state_t;

    // Latched copy of the core request; WSTRB keeps the active-low sense.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  web;
        logic [31:0] wdata;
    } core_req_t;

    state_t    state, state_nxt;
    core_req_t req_q;
    logic      err_q;

    logic ar_hs, r_last_hs, aw_hs, w_hs, b_hs;

    assign ar_hs     = axi.ARVALID && axi.ARREADY;
    assign r_last_hs = axi.RVALID && axi.RREADY && axi.RLAST;
    assign aw_hs     = axi.AWVALID && axi.AWREADY;
    assign w_hs      = axi.WVALID && axi.WREADY;
    assign b_hs      = axi.BVALID && axi.BREADY;

    // State register, cleared asynchronously so an in-flight transaction is dropped.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode; a non-RLAST R beat is accepted but does not advance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (core_req) state_nxt = (core_web != 4'b1111) ? WR_ADDR : RD_ADDR;
            RD_ADDR: if (ar_hs)     state_nxt = RD_DATA;
            RD_DATA: if (r_last_hs) state_nxt = DONE;
            WR_ADDR: if (aw_hs)     state_nxt = WR_DATA;
            WR_DATA: if (w_hs)      state_nxt = WR_RESP;
            WR_RESP: if (b_hs)      state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Request capture in IDLE, response capture on the final R beat or on B.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            req_q      <= '{addr: 32'h0, web: 4'b1111, wdata: 32'h0};
            core_rdata <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            if (state == IDLE && core_req) begin
                req_q <= '{addr: {core_addr[31:2], 2'b00}, web: core_web, wdata: core_wdata};
            end
            if (state == RD_DATA && r_last_hs) begin
                core_rdata <= axi.RDATA;
                err_q      <= (axi.RRESP != 2'b00);
            end
            if (state == WR_RESP && b_hs) begin
                err_q <= (axi.BRESP != 2'b00);
            end
        end
    end

    // Handshake outputs are pure state decodes: no AXI input reaches them.
    assign axi.ARVALID = (state == RD_ADDR);
    assign axi.RREADY  = (state == RD_DATA);
    assign axi.AWVALID = (state == WR_ADDR);
    assign axi.WVALID  = (state == WR_DATA);
    assign axi.BREADY  = (state == WR_RESP);

    assign axi.ARID    = ID_BITS'(MASTER_ID);
    assign axi.ARADDR  = req_q.addr;
    assign axi.ARLEN   = 4'd0;
    assign axi.ARSIZE  = 3'b010;
    assign axi.ARBURST = 2'b01;

    assign axi.AWID    = ID_BITS'(MASTER_ID);
    assign axi.AWADDR  = req_q.addr;
    assign axi.AWLEN   = 4'd0;
    assign axi.AWSIZE  = 3'b010;
    assign axi.AWBURST = 2'b01;

    assign axi.WDATA   = req_q.wdata;
    assign axi.WSTRB   = req_q.web;
    assign axi.WLAST   = 1'b1;

    assign core_stall = core_req && (state != DONE);
    assign core_err   = err_q && (state == DONE);

    // Response IDs and the byte offset are deliberately ignored.
    logic unused_sig;
    assign unused_sig = ^{core_addr[1:0], axi.RID, axi.BID};

endmodule

// File: tb/tb_cpu_axi_master.sv
// Directed bench for cpu_axi_master with a behavioural AXI slave and a
// queue of expected core responses.
module tb_cpu_axi_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        core_req;
    logic [31:0] core_addr;
    logic [3:0]  core_web;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic [31:0] core_rdata;
    logic        core_err;

    cpu_axi_master_if #(.ID_BITS(4)) axi ();

    cpu_axi_master #(.ID_BITS(4), .MASTER_ID(5)) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .core_req   (core_req),
        .core_addr  (core_addr),
        .core_web   (core_web),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .core_rdata (core_rdata),
        .core_err   (core_err),
        .axi        (axi)
    );

    always #5 ACLK = ~ACLK;

    // slave configuration and observations
    int          ar_wait = 0, w_wait = 0;
    bit          rd_extra_beat = 0;
    logic [31:0] rdata_cfg = 32'h0;
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    int          ar_cnt, w_cnt, rd_beats;
    bit          ar_seen, aw_done, b_pend;
    bit          ar_unstable = 0, w_before_aw = 0;
    logic [31:0] ar_first, ar_addr, aw_addr, w_data;
    logic [3:0]  ar_len, aw_len, w_strb, ar_id, aw_id;
    logic [2:0]  ar_size, aw_size;
    logic [1:0]  ar_burst, aw_burst;
    logic        w_last;

    // Slave updates on the falling edge so READY/VALID settle before each rising edge.
    always @(negedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            axi.ARREADY = 0; axi.AWREADY = 0; axi.WREADY = 0;
            axi.RVALID = 0; axi.RLAST = 0; axi.RDATA = 0; axi.RRESP = 0; axi.RID = 0;
            axi.BVALID = 0; axi.BRESP = 0; axi.BID = 0;
            ar_cnt = 0; w_cnt = 0; rd_beats = 0;
            ar_seen = 0; aw_done = 0; b_pend = 0;
        end else begin
            // R: each driven beat is taken at the next rising edge (RREADY high in RD_DATA)
            if (axi.RVALID) rd_beats--;
            if (rd_beats > 0) begin
                axi.RVALID = 1;
                axi.RLAST  = (rd_beats == 1);
                axi.RDATA  = axi.RLAST ? rdata_cfg : 32'hBAD0_BAD0;
                axi.RRESP  = axi.RLAST ? rresp_cfg : 2'b10;
                axi.RID    = 4'd5;
            end else begin
                axi.RVALID = 0;
                axi.RLAST  = 0;
            end
            // AR
            if (axi.ARVALID) begin
                if (!ar_seen) begin
                    ar_seen = 1; ar_first = axi.ARADDR;
                end else if (axi.ARADDR !== ar_first) begin
                    ar_unstable = 1;
                end
                if (ar_cnt < ar_wait) begin
                    axi.ARREADY = 0; ar_cnt++;
                end else begin
                    axi.ARREADY = 1;
                    ar_addr = axi.ARADDR; ar_len = axi.ARLEN; ar_size = axi.ARSIZE;
                    ar_burst = axi.ARBURST; ar_id = axi.ARID;
                    rd_beats = rd_extra_beat ? 2 : 1;
                    ar_cnt = 0; ar_seen = 0;
                end
            end else begin
                axi.ARREADY = 0;
            end
            // B
            if (axi.BVALID) begin
                axi.BVALID = 0;
            end else if (b_pend) begin
                axi.BVALID = 1; axi.BRESP = bresp_cfg; axi.BID = 4'd5; b_pend = 0;
            end
            // W (before AW so a W issued alongside AW is flagged)
            if (axi.WVALID) begin
                if (!aw_done) w_before_aw = 1;
                if (w_cnt < w_wait) begin
                    axi.WREADY = 0; w_cnt++;
                end else begin
                    axi.WREADY = 1;
                    w_data = axi.WDATA; w_strb = axi.WSTRB; w_last = axi.WLAST;
                    b_pend = 1; aw_done = 0; w_cnt = 0;
                end
            end else begin
                axi.WREADY = 0;
            end
            // AW
            if (axi.AWVALID) begin
                axi.AWREADY = 1;
                aw_addr = axi.AWADDR; aw_len = axi.AWLEN; aw_size = axi.AWSIZE;
                aw_burst = axi.AWBURST; aw_id = axi.AWID;
                aw_done = 1;
            end else begin
                axi.AWREADY = 0;
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_rd = 32'h0;
    int          total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request and push what the core should see on completion.
    task automatic start(input logic [31:0] a, input logic [3:0] web, input logic [31:0] wd,
                         input int lat, input bit sync);
        exp_t e;
        if (sync) begin
            @(posedge ACLK); #1;
        end
        core_req = 1; core_addr = a; core_web = web; core_wdata = wd;
        if (web == 4'b1111) begin
            last_rd = rdata_cfg;
            e.err   = (rresp_cfg != 2'b00);
        end else begin
            e.err   = (bresp_cfg != 2'b00);
        end
        e.rdata = last_rd;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    // Wait for the stall-low cycle, compare against the scoreboard head.
    task automatic finish(input bit hold);
        exp_t e;
        int   lat;
        lat = 0;
        forever begin
            @(negedge ACLK);
            if (!core_stall) break;
            lat++;
            if (lat > 60) break;
        end
        e = sb.pop_front();
        if (lat > 60) begin
            total++; bad++;
            $error("FAIL timeout observed=stall_high expected=completion");
        end else begin
            chk("latency", lat, e.lat);
            chk("core_rdata", core_rdata, e.rdata);
            chk("core_err", core_err, e.err);
        end
        @(posedge ACLK); #1;
        if (!hold) begin
            core_req = 0;
            @(negedge ACLK);
            chk("err_after_done", core_err, 1'b0);
            chk("stall_idle", core_stall, 1'b0);
            chk("rdata_hold", core_rdata, e.rdata);
        end
    endtask

    initial begin
        int n;
        ARESETn = 0; core_req = 0; core_addr = 0; core_web = 4'hF; core_wdata = 0;

        // reset state
        repeat (2) @(negedge ACLK);
        chk("rst_stall", core_stall, 1'b0);
        chk("rst_rdata", core_rdata, 32'h0);
        chk("rst_err", core_err, 1'b0);
        chk("rst_valids", {axi.ARVALID, axi.AWVALID, axi.WVALID, axi.RREADY, axi.BREADY}, 5'b0);
        chk("rst_wstrb", axi.WSTRB, 4'hF);
        core_req = 1; #1;
        chk("rst_stall_req", core_stall, 1'b1);
        core_req = 0;
        @(negedge ACLK); ARESETn = 1;

        // basic read
        rdata_cfg = 32'hDEAD_BEEF;
        start(32'h0000_0104, 4'hF, 32'h0, 3, 1);
        finish(0);
        chk("araddr", ar_addr, 32'h104);
        chk("arlen", ar_len, 4'd0);
        chk("arsize", ar_size, 3'd2);
        chk("arburst", ar_burst, 2'b01);
        chk("arid", ar_id, 4'd5);

        // basic write
        start(32'h0000_0008, 4'b1100, 32'h1234_5678, 4, 1);
        finish(0);
        chk("awaddr", aw_addr, 32'h8);
        chk("aw_fields", {aw_len, aw_size, aw_burst, aw_id}, {4'd0, 3'd2, 2'b01, 4'd5});
        chk("wstrb", w_strb, 4'b1100);
        chk("wdata", w_data, 32'h1234_5678);
        chk("wlast", w_last, 1'b1);
        chk("w_before_aw", w_before_aw, 1'b0);

        // ARREADY held off 5 cycles, unaligned address
        ar_wait = 5; rdata_cfg = 32'h0BAD_F00D;
        start(32'h0000_0203, 4'hF, 32'h0, 8, 1);
        finish(0);
        ar_wait = 0;
        chk("araddr_align", ar_addr, 32'h200);
        chk("ar_stable", ar_unstable, 1'b0);

        // read error response
        rresp_cfg = 2'b10; rdata_cfg = 32'hA5A5_0001;
        start(32'h0000_0010, 4'hF, 32'h0, 3, 1);
        finish(0);
        rresp_cfg = 2'b00;

        // write error response
        bresp_cfg = 2'b11;
        start(32'h0000_0020, 4'b0000, 32'hCAFE_0000, 4, 1);
        finish(0);
        bresp_cfg = 2'b00;

        // back-to-back read then write with core_req held
        rdata_cfg = 32'h1111_2222;
        start(32'h0000_0300, 4'hF, 32'h0, 3, 1);
        finish(1);
        start(32'h0000_0304, 4'b0111, 32'h3333_4444, 4, 0);
        finish(0);
        chk("b2b_araddr", ar_addr, 32'h300);
        chk("b2b_awaddr", aw_addr, 32'h304);
        chk("b2b_wstrb", w_strb, 4'b0111);
        chk("b2b_wdata", w_data, 32'h3333_4444);

        // non-last R beat is ignored (its data and error do not reach the core)
        rd_extra_beat = 1; rdata_cfg = 32'h5555_AAAA;
        start(32'h0000_0400, 4'hF, 32'h0, 4, 1);
        finish(0);
        rd_extra_beat = 0;

        // reset pulsed in WR_DATA
        w_wait = 10;
        @(posedge ACLK); #1;
        core_req = 1; core_addr = 32'h40; core_web = 4'b0000; core_wdata = 32'h7777_7777;
        n = 0;
        while (!axi.WVALID && n < 20) begin
            @(negedge ACLK); n++;
        end
        chk("reach_wr_data", axi.WVALID, 1'b1);
        #1 ARESETn = 0;
        #1;
        chk("rst_mid_wvalid", axi.WVALID, 1'b0);
        chk("rst_mid_valids", {axi.ARVALID, axi.AWVALID, axi.RREADY, axi.BREADY}, 4'b0);
        chk("rst_mid_stall", core_stall, 1'b1);
        chk("rst_mid_rdata", core_rdata, 32'h0);
        core_req = 0; w_wait = 0; last_rd = 32'h0;
        @(negedge ACLK);
        chk("rst_mid_idle_stall", core_stall, 1'b0);
        ARESETn = 1;

        // read after reset
        rdata_cfg = 32'h9876_5432;
        start(32'h0000_0044, 4'hF, 32'h0, 3, 1);
        finish(0);
        chk("post_rst_araddr", ar_addr, 32'h44);
        chk("w_before_aw_end", w_before_aw, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
